// File: rtl/lcd_pkg.sv
// lcd_pkg: shared LCD command bytes, geometry and FSM encodings for the frame scheduler.
package lcd_pkg;
  localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
  localparam int LCD_COLS = 16;
  localparam int LCD_CELLS = 2 * LCD_COLS;
  typedef enum logic [1:0] {G_IDLE, G_OWN, G_SWAP} g_state_t;
  typedef enum logic [2:0] {S_IDLE, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2} s_state_t;
  function automatic logic [1:0] grant_mask(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/lcd_frame_sched_if.sv
// lcd_frame_sched_if: requester write windows plus the LCD driver handshake.
interface lcd_frame_sched_if;
  logic [1:0] req;
  logic [1:0] grant;
  logic [1:0] wr_en;
  logic [9:0] wr_addr;
  logic [15:0] wr_data;
  logic abort;
  logic lcd_init_done;
  logic lcd_valid;
  logic lcd_rs;
  logic [7:0] lcd_byte;
  logic lcd_ready;
  logic busy;
  modport master (
    output req, wr_en, wr_addr, wr_data, lcd_init_done, lcd_ready,
    input grant, abort, lcd_valid, lcd_rs, lcd_byte, busy
  );
  modport slave (
    input req, wr_en, wr_addr, wr_data, lcd_init_done, lcd_ready,
    output grant, abort, lcd_valid, lcd_rs, lcd_byte, busy
  );
endinterface

// File: rtl/lcd_rr_arb.sv
// lcd_rr_arb: 2-way one-hot arbiter; LCD_RR_ARB_EN gives round-robin, otherwise requester 0 has fixed priority.
module lcd_rr_arb (
  input logic clk,
  input logic rst,
  input logic [1:0] req,
  input logic take,
  output logic [1:0] win
);
`ifdef LCD_RR_ARB_EN
  logic last;
  // last starts at 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst)
    if (!rst) last <= 1'b1;
    else if (take) last <= win[1];
  assign win = &req ? (last ? 2'b01 : 2'b10) : req;
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst, take};
  assign win = req[0] ? 2'b01 : {req[1], 1'b0};
`endif
endmodule

// File: rtl/lcd_frame_sched.sv
// lcd_frame_sched: shares a 2x16 LCD between two requesters via a double-buffered frame and a 34-transfer refresh streamer.
// Define LCD_RR_ARB_EN for round-robin arbitration; the default build uses fixed priority.
module lcd_frame_sched
  import lcd_pkg::*;
#(
  parameter int HOLD_MAX = 4096,
  parameter logic [7:0] BLANK = 8'h20
) (
  input logic clk,
  input logic rst,
  lcd_frame_sched_if.slave bus
);
  localparam int HW = $clog2(HOLD_MAX);
  g_state_t g_state, g_next;
  s_state_t s_state, s_next;
  logic own, take, drop, timeout, swap, start, stop, xfer, wr, front_sel, commit_pending, abort_q;
  logic [1:0] win;
  logic [HW-1:0] hold_cnt;
  logic [3:0] idx;
  logic [4:0] waddr;
  logic [7:0] wdata;
  logic [1:0][LCD_CELLS-1:0][7:0] bank;

  lcd_rr_arb arb (.clk(clk), .rst(rst), .req(bus.req), .take(take), .win(win));

  always_comb begin
    g_next = g_state;
    take = 1'b0;
    drop = 1'b0;
    timeout = 1'b0;
    swap = 1'b0;
    case (g_state)
      G_IDLE: begin
        take = |bus.req;
        g_next = take ? G_OWN : G_IDLE;
      end
      G_OWN: begin
        drop = !bus.req[own];
        timeout = !drop && hold_cnt == HW'(HOLD_MAX - 1);
        g_next = drop ? G_SWAP : timeout ? G_IDLE : G_OWN;
      end
      default: begin
        swap = s_state == S_IDLE;
        g_next = swap ? G_IDLE : G_SWAP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      g_state <= G_IDLE;
      own <= 1'b0;
      hold_cnt <= '0;
      abort_q <= 1'b0;
    end else begin
      g_state <= g_next;
      abort_q <= timeout;
      own <= take ? win[1] : own;
      hold_cnt <= take ? '0 : g_state == G_OWN ? hold_cnt + 1'b1 : hold_cnt;
    end

  assign wr = g_state == G_OWN && bus.wr_en[own];
  assign waddr = own ? bus.wr_addr[9:5] : bus.wr_addr[4:0];
  assign wdata = own ? bus.wr_data[15:8] : bus.wr_data[7:0];

  // swap flips banks and refreshes the new back bank from the just-committed front in one cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      front_sel <= 1'b0;
      bank <= {(2 * LCD_CELLS){BLANK}};
    end else if (swap) begin
      front_sel <= ~front_sel;
      bank[front_sel] <= bank[~front_sel];
    end else if (wr) begin
      bank[~front_sel][waddr] <= wdata;
    end

  assign xfer = bus.lcd_valid && bus.lcd_ready;
  assign start = s_state == S_IDLE && bus.lcd_init_done && commit_pending && g_state != G_SWAP;

  always_comb begin
    s_next = s_state;
    stop = 1'b0;
    if (s_state == S_IDLE) s_next = start ? S_ADDR1 : S_IDLE;
    else if (xfer) begin
      stop = !bus.lcd_init_done;
      s_next = stop ? S_IDLE :
               s_state == S_ADDR1 ? S_LINE1 :
               s_state == S_ADDR2 ? S_LINE2 :
               idx != 4'(LCD_COLS - 1) ? s_state :
               s_state == S_LINE1 ? S_ADDR2 : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s_state <= S_IDLE;
      idx <= '0;
    end else begin
      s_state <= s_next;
      idx <= s_state == S_IDLE ? 4'd0 : xfer && bus.lcd_rs ? idx + 4'd1 : idx;
    end

  // a release or an interrupted stream both schedule a full-frame resend; setting beats clearing
  always_ff @(posedge clk or negedge rst)
    if (!rst) commit_pending <= 1'b1;
    else commit_pending <= drop || stop ? 1'b1 : start ? 1'b0 : commit_pending;

  assign bus.grant = g_state == G_OWN ? grant_mask(own) : 2'b00;
  assign bus.abort = abort_q;
  assign bus.busy = s_state != S_IDLE;
  assign bus.lcd_valid = s_state != S_IDLE;
  assign bus.lcd_rs = s_state == S_LINE1 || s_state == S_LINE2;
  assign bus.lcd_byte = s_state == S_ADDR1 ? LCD_CMD_LINE1 :
                        s_state == S_ADDR2 ? LCD_CMD_LINE2 :
                        bus.lcd_rs ? bank[front_sel][{s_state == S_LINE2, idx}] : 8'h00;
endmodule

// File: tb/tb_lcd_frame_sched.sv
// tb_lcd_frame_sched: directed checks of arbitration, commit, timeout, stall, torn-frame and reset behaviour.
module tb_lcd_frame_sched;
  localparam int HOLD = 4096;
  localparam logic [7:0] BL = 8'h20;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [8:0] xf [$];
  logic [7:0] disp [32];
  logic [7:0] bk [32];
  logic [7:0] d1 [32];
`ifdef LCD_RR_ARB_EN
  logic [1:0] arb_exp [3] = '{2'b01, 2'b10, 2'b01};
`else
  logic [1:0] arb_exp [3] = '{2'b01, 2'b01, 2'b01};
`endif

  lcd_frame_sched_if bus ();
  lcd_frame_sched dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // each negedge sample with valid && ready is the transfer taken at the following posedge
  always @(negedge clk)
    if (rst && bus.lcd_valid && bus.lcd_ready) xf.push_back({bus.lcd_rs, bus.lcd_byte});

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant();
    int t = 0;
    while (bus.grant == 2'b00 && t < 300) begin
      tick(1);
      t++;
    end
  endtask

  task automatic wait_size(input int n);
    int t = 0;
    while (xf.size() < n && t < 300) begin
      tick(1);
      t++;
    end
    chk("reach_transfer", xf.size(), n);
  endtask

  task automatic wait_frame(input int n);
    int t = 0;
    while ((xf.size() < n || bus.busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_len", xf.size(), n);
    tick(1);
  endtask

  task automatic check_frame(input string tag, input int off, input logic [7:0] f [32]);
    for (int i = 0; i < 34; i++) begin
      int k;
      logic [8:0] e;
      k = i < 17 ? i - 1 : i - 2;
      e = i == 0 ? 9'h080 : i == 17 ? 9'h0C0 : {1'b1, f[k[4:0]]};
      chk($sformatf("%s[%0d]", tag, i), {23'd0, xf[off + i]}, {23'd0, e});
    end
  endtask

  initial begin
    bus.req = 2'b00;
    bus.wr_en = 2'b00;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.lcd_init_done = 1'b0;
    bus.lcd_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      disp[i] = BL;
      bk[i] = BL;
    end
    tick(3);
    chk("rst_grant", bus.grant, 2'b00);
    chk("rst_abort", bus.abort, 0);
    chk("rst_valid", bus.lcd_valid, 0);
    chk("rst_rs", bus.lcd_rs, 0);
    chk("rst_byte", bus.lcd_byte, 8'h00);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b1;
    tick(2);
    chk("no_init_valid", bus.lcd_valid, 0);

    xf.delete();
    bus.lcd_init_done = 1'b1;
    bus.lcd_ready = 1'b1;
    wait_frame(34);
    check_frame("blank", 0, disp);
    chk("blank_busy_after", bus.busy, 0);

    for (int r = 0; r < 3; r++) begin
      bus.req = 2'b11;
      wait_grant();
      chk($sformatf("arb_round%0d", r), bus.grant, arb_exp[r]);
      bus.req = 2'b00;
      tick(1);
    end
    tick(200);
    chk("arb_quiet_busy", bus.busy, 0);

    xf.delete();
    bus.req = 2'b01;
    wait_grant();
    chk("own0_grant", bus.grant, 2'b01);
    bus.wr_en = 2'b11;
    bus.wr_addr = {5'd5, 5'd0};
    bus.wr_data = {8'h51, 8'h41};
    tick(1);
    bus.wr_en = 2'b01;
    bus.wr_addr = {5'd5, 5'd31};
    bus.wr_data = {8'h51, 8'h5A};
    tick(1);
    bus.wr_en = 2'b00;
    bus.req = 2'b00;
    tick(1);
    chk("own0_release", bus.grant, 2'b00);
    bk[0] = 8'h41;
    bk[31] = 8'h5A;
    disp = bk;
    wait_frame(34);
    check_frame("frame_az", 0, disp);

    xf.delete();
    bus.req = 2'b10;
    wait_grant();
    chk("own1_grant", bus.grant, 2'b10);
    bus.wr_en = 2'b10;
    bus.wr_addr = {5'd3, 5'd0};
    bus.wr_data = {8'h58, 8'h00};
    tick(1);
    bus.wr_en = 2'b00;
    bk[3] = 8'h58;
    tick(HOLD - 2);
    chk("hold_last_grant", bus.grant, 2'b10);
    chk("hold_no_abort", bus.abort, 0);
    tick(1);
    chk("timeout_abort", bus.abort, 1);
    chk("timeout_grant", bus.grant, 2'b00);
    bus.req = 2'b00;
    tick(1);
    chk("abort_pulse_end", bus.abort, 0);
    tick(50);
    chk("abort_no_stream", xf.size(), 0);
    chk("abort_busy", bus.busy, 0);

    xf.delete();
    bus.req = 2'b01;
    wait_grant();
    bus.wr_en = 2'b01;
    bus.wr_addr = {5'd0, 5'd4};
    bus.wr_data = {8'h00, 8'h48};
    tick(1);
    bus.wr_en = 2'b00;
    bus.req = 2'b00;
    tick(1);
    bk[4] = 8'h48;
    disp = bk;
    wait_size(5);
    bus.lcd_ready = 1'b0;
    chk("stall_first", {bus.lcd_valid, bus.lcd_rs, bus.lcd_byte}, 10'h348);
    for (int c = 0; c < 20; c++) begin
      tick(1);
      chk($sformatf("stall_hold%0d", c), {bus.lcd_valid, bus.lcd_rs, bus.lcd_byte}, 10'h348);
    end
    chk("stall_no_xfer", xf.size(), 5);
    bus.lcd_ready = 1'b1;
    wait_frame(34);
    check_frame("stall_frame", 0, disp);

    xf.delete();
    bus.req = 2'b01;
    wait_grant();
    bus.wr_en = 2'b01;
    bus.wr_addr = {5'd0, 5'd0};
    bus.wr_data = {8'h00, 8'h42};
    tick(1);
    bus.wr_en = 2'b00;
    bus.req = 2'b10;
    tick(1);
    bk[0] = 8'h42;
    disp = bk;
    d1 = disp;
    wait_grant();
    chk("mid_grant1", bus.grant, 2'b10);
    bus.wr_en = 2'b10;
    bus.wr_addr = {5'd10, 5'd0};
    bus.wr_data = {8'h43, 8'h00};
    tick(1);
    bus.wr_en = 2'b00;
    bk[10] = 8'h43;
    wait_size(10);
    bus.req = 2'b00;
    tick(1);
    chk("mid_commit_busy", bus.busy, 1);
    disp = bk;
    wait_frame(68);
    check_frame("untorn", 0, d1);
    check_frame("updated", 34, disp);

    xf.delete();
    bus.req = 2'b01;
    wait_grant();
    bus.req = 2'b00;
    tick(1);
    wait_size(8);
    bus.lcd_init_done = 1'b0;
    tick(5);
    chk("init_drop_busy", bus.busy, 0);
    chk("init_drop_partial", xf.size(), 9);
    xf.delete();
    bus.lcd_init_done = 1'b1;
    wait_frame(34);
    check_frame("resend", 0, disp);

    xf.delete();
    bus.req = 2'b01;
    wait_grant();
    bus.req = 2'b00;
    tick(1);
    wait_size(5);
    rst = 1'b0;
    #1;
    chk("async_valid", bus.lcd_valid, 0);
    chk("async_busy", bus.busy, 0);
    chk("async_byte", bus.lcd_byte, 8'h00);
    chk("async_grant", bus.grant, 2'b00);
    for (int i = 0; i < 32; i++) disp[i] = BL;
    tick(2);
    rst = 1'b1;
    xf.delete();
    wait_frame(34);
    check_frame("post_reset", 0, disp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
